// File: rtl/ctx_sequencer.sv
// ctx_sequencer: loads the CGRA context RAM from the host on port A and streams
// a programmed, optionally looped, window of context words to the PE array from
// port B through a 2-entry output FIFO with a bypass path for minimum latency.
module ctx_sequencer #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32,
    parameter int LWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              start,
    input  logic              abort,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   num_ctx,
    input  logic [LWIDTH-1:0] num_loops,
    output logic              busy,
    output logic              done,
    output logic              ctx_valid,
    input  logic              ctx_ready,
    output logic [DWIDTH-1:0] ctx_data,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [AWIDTH-1:0] ram_addra,
    output logic [DWIDTH-1:0] ram_dina,
    output logic              ram_enb,
    output logic              ram_web,
    output logic [AWIDTH-1:0] ram_addrb,
    input  logic [DWIDTH-1:0] ram_doutb
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_next;
    logic              armed;
    logic [AWIDTH-1:0] base_r, rd_addr, rd_addr_next;
    logic [AWIDTH:0]   num_ctx_r, issue_cnt, issue_cnt_next, issue_cnt_inc;
    logic [LWIDTH-1:0] num_loops_r, pass_cnt, pass_cnt_next;
    logic              inflight;
    logic [DWIDTH-1:0] fifo_mem [2];
    logic              fifo_wptr, fifo_rptr;
    logic [1:0]        fifo_count, occupancy;
    logic              fifo_empty, fifo_push, fifo_pop, pop;
    logic              wr_accept, issue, flush, capture;

    // Host write channel: port A follows an accepted write combinationally;
    // armed keeps every output low until the first clock after reset.
    assign wr_ready  = armed && (state == IDLE);
    assign wr_accept = wr_valid && wr_ready;
    assign ram_ena   = wr_accept;
    assign ram_wea   = wr_accept;
    assign ram_addra = wr_accept ? wr_addr : '0;
    assign ram_dina  = wr_accept ? wr_data : '0;

    // Port B is read-only and only addressed when a read is issued
    assign ram_web   = 1'b0;
    assign ram_enb   = issue;
    assign ram_addrb = issue ? rd_addr : '0;

    // Output side: FIFO head when occupied, otherwise the returning RAM word
    // bypasses the FIFO so the first word appears two cycles after start.
    assign fifo_empty    = (fifo_count == 2'd0);
    assign ctx_valid     = !fifo_empty || inflight;
    assign ctx_data      = !fifo_empty ? fifo_mem[fifo_rptr] : (inflight ? ram_doutb : '0);
    assign pop           = ctx_valid && ctx_ready;
    assign fifo_push     = inflight && !(fifo_empty && pop);
    assign fifo_pop      = pop && !fifo_empty;
    assign occupancy     = fifo_count + {1'b0, inflight};
    assign issue_cnt_inc = issue_cnt + (AWIDTH+1)'(1);

    // Next-state, read-issue and window/loop counter logic
    always_comb begin
        state_next     = state;
        issue          = 1'b0;
        flush          = 1'b0;
        capture        = 1'b0;
        done           = 1'b0;
        busy           = 1'b0;
        rd_addr_next   = rd_addr;
        issue_cnt_next = issue_cnt;
        pass_cnt_next  = pass_cnt;
        case (state)
            IDLE: begin
                if (armed && start) begin
                    capture = 1'b1;
                    if (num_ctx == '0) begin
                        state_next = DONE;
                    end else begin
                        rd_addr_next   = base_addr;
                        issue_cnt_next = '0;
                        pass_cnt_next  = '0;
                        state_next     = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    flush      = 1'b1;
                    state_next = DONE;
                end else if (occupancy < 2'd2) begin
                    issue          = 1'b1;
                    rd_addr_next   = rd_addr + AWIDTH'(1);
                    issue_cnt_next = issue_cnt_inc;
                    if (issue_cnt_inc == num_ctx_r) begin
                        if (pass_cnt < num_loops_r) begin
                            pass_cnt_next  = pass_cnt + LWIDTH'(1);
                            issue_cnt_next = '0;
                            rd_addr_next   = base_r;
                        end else begin
                            state_next = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    flush      = 1'b1;
                    state_next = DONE;
                end else if (!inflight && fifo_empty) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and post-reset arming flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    // Sequence parameters captured on start, plus the address and pass counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r      <= '0;
            num_ctx_r   <= '0;
            num_loops_r <= '0;
            rd_addr     <= '0;
            issue_cnt   <= '0;
            pass_cnt    <= '0;
        end else begin
            if (capture) begin
                base_r      <= base_addr;
                num_ctx_r   <= num_ctx;
                num_loops_r <= num_loops;
            end
            rd_addr   <= rd_addr_next;
            issue_cnt <= issue_cnt_next;
            pass_cnt  <= pass_cnt_next;
        end
    end

    // In-flight read flag and 2-entry output FIFO; abort discards both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_wptr   <= 1'b0;
            fifo_rptr   <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else if (flush) begin
            inflight   <= 1'b0;
            fifo_count <= 2'd0;
            fifo_wptr  <= 1'b0;
            fifo_rptr  <= 1'b0;
        end else begin
            inflight <= issue;
            if (fifo_push) begin
                fifo_mem[fifo_wptr] <= ram_doutb;
                fifo_wptr           <= ~fifo_wptr;
            end
            if (fifo_pop) begin
                fifo_rptr <= ~fifo_rptr;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
